// File: rtl/q_8_10_multi_pkg.sv
// Shared types and transition table for the multi-channel x/y controller.
// Optional dwell counters are enabled with the DWELL_CNT_EN macro.
package q_8_10_multi_pkg;

    typedef enum logic [1:0] {
        S_0 = 2'd0,
        S_1 = 2'd1,
        S_2 = 2'd2,
        S_3 = 2'd3
    } state_t;

    function automatic state_t next_state_f(
        input state_t s,
        input logic   x,
        input logic   y
    );
        state_t n;
        n = S_0;
        case (s)
            S_0: n = x ? S_1 : S_0;
            S_1: n = y ? S_3 : S_2;
            S_2: begin
                if (x && y)
                    n = S_3;
                else if (x)
                    n = S_2;
                else
                    n = S_0;
            end
            S_3: begin
                if (!x && y)
                    n = S_3;
                else if (!x)
                    n = S_2;
                else
                    n = S_0;
            end
            default: n = S_0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/q_8_10_multi_chan.sv
// One controller channel: state, S_3 entry pulse, optional dwell counter.
// Dwell counter is built only when DWELL_CNT_EN is defined.
module q_8_10_chan
    import q_8_10_multi_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    input  logic             y,
    output state_t           state,
    output logic             hit,
    output logic [CNT_W-1:0] dwell
);

    state_t r_state;
    logic   r_hit;
    state_t w_next;

    assign w_next = next_state_f(r_state, x, y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_0;
            r_hit   <= 1'b0;
        end else if (clr) begin
            r_state <= S_0;
            r_hit   <= 1'b0;
        end else if (en) begin
            r_state <= w_next;
            r_hit   <= (w_next == S_3) && (r_state != S_3);
        end else begin
            r_hit   <= 1'b0;
        end
    end

    assign state = r_state;
    assign hit   = r_hit;

`ifdef DWELL_CNT_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_dwell;
    logic             w_chg;
    logic             w_sat;

    // self-loops keep counting; only a real state change restarts
    assign w_chg = en && (w_next != r_state);
    assign w_sat = &r_dwell;

    always_ff @(posedge clk) begin
        if (rst || clr || w_chg)
            r_dwell <= '0;
        else if (!w_sat)
            r_dwell <= r_dwell + ONE;
    end

    assign dwell = r_dwell;
`else
    assign dwell = '0;
`endif

endmodule

// File: rtl/q_8_10_multi.sv
// CHANNELS independent x/y controllers sharing clock and reset.
// Dwell counters are present only when DWELL_CNT_EN is defined.
module q_8_10_multi
    import q_8_10_multi_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       x,
    input  logic [CHANNELS-1:0]       y,
    output state_t [CHANNELS-1:0]     state,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS*CNT_W-1:0] dwell,
    output logic                      any_s3
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        q_8_10_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .en    (en[g]),
            .clr   (clr[g]),
            .x     (x[g]),
            .y     (y[g]),
            .state (state[g]),
            .hit   (hit[g]),
            .dwell (dwell[g*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        any_s3 = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            any_s3 = any_s3 | (state[i] == S_3);
    end

endmodule

// File: tb/tb_q_8_10_multi.sv
// Self-checking bench for q_8_10_multi: table-driven reference model
// plus directed literal expectations; 4 channels, 4-bit dwell.
module tb_q_8_10_multi;
    import q_8_10_multi_pkg::*;

    localparam int NC   = 4;
    localparam int CW   = 4;
    localparam int DMAX = 15;

    logic            clk;
    logic            rst;
    logic [NC-1:0]   en, clr, x, y;
    state_t [NC-1:0] st;
    logic [NC-1:0]   hit;
    logic [NC*CW-1:0] dwell;
    logic            any_s3;

    int checks = 0;
    int errors = 0;

    // next state indexed [state][{x,y}]
    int tbl [4][4] = '{'{0, 0, 1, 1},
                       '{2, 3, 2, 3},
                       '{0, 0, 2, 3},
                       '{2, 3, 0, 0}};

    int m_st [NC];
    int m_hit [NC];
    int m_dw [NC];
    bit m_valid = 0;

    q_8_10_multi #(
        .CHANNELS (NC),
        .CNT_W    (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (clr),
        .x      (x),
        .y      (y),
        .state  (st),
        .hit    (hit),
        .dwell  (dwell),
        .any_s3 (any_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ed(int v);
`ifdef DWELL_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int dw(int ch);
        return int'(dwell[ch*CW +: CW]);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            int n;
            n = tbl[m_st[i]][{x[i], y[i]}];
            if (rst) begin
                m_st[i] = 0; m_hit[i] = 0; m_dw[i] = 0;
            end else if (clr[i]) begin
                m_st[i] = 0; m_hit[i] = 0; m_dw[i] = 0;
            end else if (en[i]) begin
                m_hit[i] = (n == 3 && m_st[i] != 3) ? 1 : 0;
                m_dw[i]  = (n != m_st[i]) ? 0 :
                           (m_dw[i] < DMAX ? m_dw[i] + 1 : DMAX);
                m_st[i]  = n;
            end else begin
                m_hit[i] = 0;
                m_dw[i]  = m_dw[i] < DMAX ? m_dw[i] + 1 : DMAX;
            end
        end
        m_valid = 1;
    end

    // compare process
    always @(negedge clk) begin
        if (m_valid) begin
            int a;
            a = 0;
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("model_state%0d", i), int'(st[i]), m_st[i]);
                chk($sformatf("model_hit%0d", i), int'(hit[i]), m_hit[i]);
                chk($sformatf("model_dwell%0d", i), dw(i), ed(m_dw[i]));
                if (m_st[i] == 3) a = 1;
            end
            chk("model_any_s3", int'(any_s3), a);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(int ch, bit e, bit c, bit xv, bit yv);
        en[ch] = e; clr[ch] = c; x[ch] = xv; y[ch] = yv;
    endtask

    task automatic lit(string nm, int ch, int s, int h, int d);
        chk({nm, "_state"}, int'(st[ch]), s);
        chk({nm, "_hit"}, int'(hit[ch]), h);
        chk({nm, "_dwell"}, dw(ch), ed(d));
    endtask

    int wx [4] = '{1, 0, 1, 0};
    int wy [4] = '{0, 0, 1, 1};
    int ws [4] = '{1, 2, 3, 3};
    int wh [4] = '{0, 0, 1, 0};
    int wd [4] = '{0, 0, 0, 1};

    initial begin
        rst = 1'b1;
        clr = '0;
        for (int k = 0; k < 2; k++) begin
            en = NC'($urandom); x = NC'($urandom); y = NC'($urandom);
            cyc();
        end
        for (int i = 0; i < NC; i++)
            lit($sformatf("reset_ch%0d", i), i, 0, 0, 0);
        chk("reset_any_s3", int'(any_s3), 0);

        rst = 1'b0; en = '0; x = '0; y = '0;

        // path walk, channel 0
        for (int k = 0; k < 4; k++) begin
            drv(0, 1, 0, wx[k][0], wy[k][0]);
            cyc();
            lit($sformatf("walk%0d", k), 0, ws[k], wh[k], wd[k]);
        end
        chk("walk_any_s3", int'(any_s3), 1);

        // hold in S_3 with en low
        drv(0, 0, 0, 1, 0);
        repeat (5) cyc();
        lit("hold", 0, 3, 0, 6);

        // clear beats enable
        drv(0, 1, 1, 1, 1);
        cyc();
        lit("clr", 0, 0, 0, 0);

        // back to S_3 then reset mid-sequence
        drv(0, 1, 0, 1, 0); cyc();
        drv(0, 1, 0, 0, 1); cyc();
        lit("pre_rst", 0, 3, 1, 0);
        rst = 1'b1; cyc();
        lit("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_any", int'(any_s3), 0);
        rst = 1'b0; drv(0, 0, 0, 0, 0);

        // channel 1 exits from S_2/S_3
        drv(1, 1, 0, 1, 0); cyc(); lit("c1_s1", 1, 1, 0, 0);
        drv(1, 1, 0, 0, 0); cyc(); lit("c1_s2", 1, 2, 0, 0);
        drv(1, 1, 0, 1, 0); cyc(); lit("c1_s2a", 1, 2, 0, 1);
        cyc();                     lit("c1_s2b", 1, 2, 0, 2);
        drv(1, 1, 0, 1, 1); cyc(); lit("c1_s3", 1, 3, 1, 0);
        drv(1, 1, 0, 0, 0); cyc(); lit("c1_s3to2", 1, 2, 0, 0);
        drv(1, 1, 0, 1, 1); cyc(); lit("c1_s3b", 1, 3, 1, 0);
        cyc();                     lit("c1_s3to0", 1, 0, 0, 0);
        drv(1, 0, 0, 0, 0);

        // saturation, channel 2
        drv(2, 1, 1, 0, 0); cyc();
        drv(2, 1, 0, 0, 0);
        repeat (15) cyc();
        lit("sat15", 2, 0, 0, 15);
        repeat (5) cyc();
        lit("sat20", 2, 0, 0, 15);
        drv(2, 1, 0, 1, 0); cyc();
        lit("sat_exit", 2, 1, 0, 0);
        drv(2, 0, 0, 0, 0);

        // independent random traffic
        for (int k = 0; k < 10000; k++) begin
            rst = ($urandom_range(0, 999) == 0);
            for (int i = 0; i < NC; i++) begin
                en[i]  = ($urandom_range(0, 3) != 0);
                clr[i] = ($urandom_range(0, 15) == 0);
                x[i]   = 1'($urandom);
                y[i]   = 1'($urandom);
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
